// File: rtl/alu_share_arbiter.sv
// Purpose : shares one combinational alu_math datapath between NUM_REQ requesters, one op per cycle,
//           and returns each result tagged with the owning requester ID.
// Latency : accept in cycle N -> rsp_valid_o in cycle N+1. Draining and refilling in the same cycle gives 1 op/cycle.
// Backpr. : while the one-entry response buffer is full and rsp_ready_i=0, every req_ready_o is 0.
//
// Ports   : clk_i/arst_ni (async active-low); req_* per-requester valid/ready plus func/rs1/rs2/imm;
//           alu_* operands driven to the ALU and alu_result_i back from it; rsp_* buffered result with its id.
// Config  : define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); otherwise round-robin.

package simple_processor_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

module alu_share_arbiter
    import simple_processor_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                                  clk_i,
    input  logic                                  arst_ni,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    input  logic [NUM_REQ-1:0][1:0]               req_func_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_rs1_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_rs2_i,
    input  logic [NUM_REQ-1:0][5:0]               req_imm_i,
    output logic [1:0]                            alu_func_o,
    output logic [DATA_WIDTH-1:0]                 alu_rs1_o,
    output logic [DATA_WIDTH-1:0]                 alu_rs2_o,
    output logic [5:0]                            alu_imm_o,
    input  logic [DATA_WIDTH-1:0]                 alu_result_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                 rsp_data_o,
    output logic [ID_WIDTH-1:0]                   rsp_id_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

    logic                  can_issue;
    logic                  any_vld;
    logic                  grant_vld;
    logic                  accept;
    logic [ID_WIDTH-1:0]   gnt;
    logic [ID_WIDTH-1:0]   alu_sel;

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;

    // A full buffer can take a new result only when it is being drained this same cycle.
    assign can_issue = (state_q == EMPTY) | (rsp_valid_o & rsp_ready_i);
    assign any_vld   = |req_valid_i;
    assign grant_vld = can_issue & any_vld;
    // The grant always lands on a valid port when any is valid, so this is the accept condition.
    assign accept    = grant_vld;

`ifdef ALU_ARB_FIXED_PRIO_EN

    // Lowest valid index wins; with nothing valid the grant rests on port 0.
    always_comb begin
        gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                gnt = ID_WIDTH'(i);
            end
        end
    end

`else

    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH:0]   rr_sum;
    logic [ID_WIDTH-1:0] rr_idx;
    logic                rr_found;

    // Search starts at rr_ptr and wraps modulo NUM_REQ. With nothing valid the grant
    // rests on the pointed port, so its ready can be high before its valid rises.
    always_comb begin
        gnt      = rr_ptr_q;
        rr_found = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(i);
            if (rr_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[ID_WIDTH-1:0];
            if (!rr_found && req_valid_i[rr_idx]) begin
                gnt      = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only on an accept.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`endif

    // Ready is independent of the port's own valid; it only reflects capacity and selection.
    always_comb begin
        req_ready_o = '0;
        for (int g = 0; g < NUM_REQ; g++) begin
            req_ready_o[g] = can_issue & (gnt == ID_WIDTH'(g));
        end
    end

    // With no grant the ALU just sees port 0; its result is ignored in that case.
    assign alu_sel    = grant_vld ? gnt : '0;
    assign alu_func_o = req_func_i[alu_sel];
    assign alu_rs1_o  = req_rs1_i[alu_sel];
    assign alu_rs2_o  = req_rs2_i[alu_sel];
    assign alu_imm_o  = req_imm_i[alu_sel];

    // Buffer FSM: accept always (re)fills, a drain without a refill empties.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (rsp_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            rsp_data_d = alu_result_i;
            rsp_id_d   = gnt;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

endmodule
